// File: rtl/lfsr_prbs_check.sv
// Receive-side PRBS checker: self-synchronises to the Fibonacci LFSR sequence
// s[n] = s[n-(MSB+1)] ^ s[n-(TAP2+1)], then flywheels and counts bit errors.
module lfsr_prbs_check #(
    parameter int MSB      = 21,
    parameter int TAP2     = 19,
    parameter int LOCK_CNT = 64,
    parameter int WINDOW   = 1024,
    parameter int LOSS_THR = 32
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clr,
    output logic        locked,
    output logic        err_pulse,
    output logic        sync_loss,
    output logic [31:0] bit_cnt,
    output logic [31:0] err_cnt
);

    localparam int N  = MSB + 1;
    localparam int SW = $clog2(N + 1);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(LOSS_THR + 1);

    localparam logic [SW-1:0] SEED_LAST = SW'(N - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(LOSS_THR - 1);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    state_t          state, state_nx;
    logic [MSB:0]    h, h_nx;
    logic [SW-1:0]   seed_cnt, seed_cnt_nx;
    logic [RW-1:0]   run_cnt, run_cnt_nx;
    logic [WW-1:0]   win_cnt, win_cnt_nx;
    logic [EW-1:0]   win_err, win_err_nx;
    logic            locked_nx, err_pulse_nx, sync_loss_nx;
    logic [31:0]     bit_cnt_nx, err_cnt_nx;
    logic [1:0]      rst_q;
    logic            run;
    logic            pred, miss;
    logic [MSB:0]    h_din;

    // Reset asserts immediately; release is re-timed to sclk by two flops.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end
    assign run = rst_q[1];

    assign pred  = h[MSB] ^ h[TAP2];
    assign miss  = din ^ pred;
    assign h_din = {h[MSB-1:0], din};

    always_comb begin
        state_nx     = state;
        h_nx         = h;
        seed_cnt_nx  = seed_cnt;
        run_cnt_nx   = run_cnt;
        win_cnt_nx   = win_cnt;
        win_err_nx   = win_err;
        locked_nx    = locked;
        err_pulse_nx = 1'b0;
        sync_loss_nx = 1'b0;
        bit_cnt_nx   = bit_cnt;
        err_cnt_nx   = err_cnt;
        if (din_valid) begin
            unique case (state)
                SEED: begin
                    h_nx = h_din;
                    if (seed_cnt == SEED_LAST) begin
                        seed_cnt_nx = '0;
                        if (h_din != '0) begin
                            state_nx   = VERIFY;
                            run_cnt_nx = '0;
                        end
                    end else begin
                        seed_cnt_nx = seed_cnt + SW'(1);
                    end
                end
                VERIFY: begin
                    if (!miss) begin
                        h_nx = h_din;
                        if (run_cnt == RUN_LAST) begin
                            state_nx   = LOCKED;
                            locked_nx  = 1'b1;
                            run_cnt_nx = '0;
                        end else begin
                            run_cnt_nx = run_cnt + RW'(1);
                        end
                    end else begin
                        state_nx    = SEED;
                        seed_cnt_nx = '0;
                        run_cnt_nx  = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: feed back our own prediction so a bad bit
                    // cannot corrupt later predictions.
                    h_nx         = {h[MSB-1:0], pred};
                    err_pulse_nx = miss;
                    if (!(&bit_cnt))          bit_cnt_nx = bit_cnt + 32'd1;
                    if (miss && !(&err_cnt))  err_cnt_nx = err_cnt + 32'd1;
                    if (miss && win_err == ERR_LAST) begin
                        state_nx     = SEED;
                        locked_nx    = 1'b0;
                        sync_loss_nx = 1'b1;
                        h_nx         = '0;
                        seed_cnt_nx  = '0;
                        run_cnt_nx   = '0;
                        win_cnt_nx   = '0;
                        win_err_nx   = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt_nx = '0;
                        win_err_nx = '0;
                    end else begin
                        win_cnt_nx = win_cnt + WW'(1);
                        if (miss) win_err_nx = win_err + EW'(1);
                    end
                end
                default: state_nx = SEED;
            endcase
        end
        if (clr) begin
            bit_cnt_nx = '0;
            err_cnt_nx = '0;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            h         <= '0;
            seed_cnt  <= '0;
            run_cnt   <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            sync_loss <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
        end else if (!run) begin
            state     <= SEED;
            h         <= '0;
            seed_cnt  <= '0;
            run_cnt   <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            sync_loss <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            h         <= h_nx;
            seed_cnt  <= seed_cnt_nx;
            run_cnt   <= run_cnt_nx;
            win_cnt   <= win_cnt_nx;
            win_err   <= win_err_nx;
            locked    <= locked_nx;
            err_pulse <= err_pulse_nx;
            sync_loss <= sync_loss_nx;
            bit_cnt   <= bit_cnt_nx;
            err_cnt   <= err_cnt_nx;
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_check.sv
// Scoreboard bench for lfsr_prbs_check: a bit-history reference model pushes
// expected outputs per driven cycle; a monitor pops and compares each cycle.
module tb_lfsr_prbs_check;

    logic        sclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err_pulse, sync_loss;
    logic [31:0] bit_cnt, err_cnt;

    lfsr_prbs_check dut (
        .sclk(sclk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .sync_loss(sync_loss),
        .bit_cnt(bit_cnt), .err_cnt(err_cnt)
    );

    always #10 sclk = ~sclk;

    typedef struct {
        bit          lk;
        bit          ep;
        bit          sl;
        int unsigned bc;
        int unsigned ec;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   ep_seen = 0;
    int   sl_seen = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents outputs every cycle; compare one entry per edge.
    always @(posedge sclk) begin : mon
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("locked",    locked,    e.lk);
            chk("err_pulse", err_pulse, e.ep);
            chk("sync_loss", sync_loss, e.sl);
            chk("bit_cnt",   bit_cnt,   e.bc);
            chk("err_cnt",   err_cnt,   e.ec);
        end
        ep_seen += int'(err_pulse);
        sl_seen += int'(sync_loss);
    end

    // Reference model: the 22 most recent sequence bits, oldest first.
    localparam int M_SEED = 0, M_VER = 1, M_LOCK = 2;
    localparam int unsigned CMAX = 32'hFFFF_FFFF;
    int          mode;
    bit          hist[$];
    int          seed_n, run_n, win_n, win_e;
    int unsigned bcnt, ecnt;

    function automatic void model_clear_local();
        hist = {};
        repeat (22) hist.push_back(1'b0);
        seed_n = 0; run_n = 0; win_n = 0; win_e = 0;
    endfunction

    function automatic void model_reset();
        model_clear_local();
        mode = M_SEED; bcnt = 0; ecnt = 0;
    endfunction

    task automatic model_step(input bit d, input bit v, input bit c);
        exp_t e;
        bit   pred;
        int   ones;
        e.ep = 1'b0;
        e.sl = 1'b0;
        if (v) begin
            pred = hist[0] ^ hist[2];
            case (mode)
                M_SEED: begin
                    void'(hist.pop_front()); hist.push_back(d);
                    seed_n++;
                    if (seed_n == 22) begin
                        seed_n = 0;
                        ones = 0;
                        foreach (hist[i]) ones += int'(hist[i]);
                        if (ones != 0) begin mode = M_VER; run_n = 0; end
                    end
                end
                M_VER: begin
                    if (d == pred) begin
                        void'(hist.pop_front()); hist.push_back(d);
                        run_n++;
                        if (run_n == 64) mode = M_LOCK;
                    end else begin
                        mode = M_SEED; seed_n = 0;
                    end
                end
                default: begin
                    void'(hist.pop_front()); hist.push_back(pred);
                    if (bcnt != CMAX) bcnt++;
                    win_n++;
                    if (d != pred) begin
                        e.ep = 1'b1;
                        if (ecnt != CMAX) ecnt++;
                        win_e++;
                    end
                    if (win_e == 32) begin
                        e.sl = 1'b1; mode = M_SEED; model_clear_local();
                    end else if (win_n == 1024) begin
                        win_n = 0; win_e = 0;
                    end
                end
            endcase
        end
        if (c) begin bcnt = 0; ecnt = 0; end
        e.lk = (mode == M_LOCK);
        e.bc = bcnt;
        e.ec = ecnt;
        expq.push_back(e);
    endtask

    // Reference sequence source, oldest of the last 22 bits at index 0.
    bit gq[$];
    function automatic bit gen_next();
        bit b;
        b = gq[0] ^ gq[2];
        void'(gq.pop_front());
        gq.push_back(b);
        return b;
    endfunction

    task automatic send(input bit d, input bit v, input bit c);
        @(negedge sclk);
        din = d; din_valid = v; clr = c;
        model_step(d, v, c);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send(gen_next(), 1'b1, 1'b0);
    endtask

    task automatic settle();
        @(posedge sclk); #2;
    endtask

    task automatic lock_check(input string tag);
        send_clean(85); settle(); chk({tag, "_unlocked_at_85"}, locked, 0);
        send_clean(1);  settle(); chk({tag, "_locked_at_86"},   locked, 1);
    endtask

    task automatic hard_reset();
        @(posedge sclk); #3;
        din_valid = 1'b0; clr = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_locked",    locked,    0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_sync_loss", sync_loss, 0);
        chk("rst_bit_cnt",   bit_cnt,   0);
        chk("rst_err_cnt",   err_cnt,   0);
        #9;
        rst_n = 1'b1;
        repeat (3) send(1'b0, 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [21:0] seed;
        int ep0, sl0;
        bit b, v;
        seed = 22'h1A5555;
        for (int i = 0; i < 22; i++) gq.push_back(seed[i]);
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge sclk);
        chk("init_locked",  locked,  0);
        chk("init_bit_cnt", bit_cnt, 0);
        chk("init_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        repeat (3) send(1'b0, 1'b0, 1'b0);

        // 1: clean stream
        lock_check("t1");
        send_clean(10000); settle();
        chk("t1_bit_cnt", bit_cnt, 10000);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_pulses",  ep_seen, 0);

        // 2: isolated errors, then random gaps with sparse errors
        ep0 = ep_seen;
        for (int k = 0; k < 5; k++) begin
            send_clean(99);
            send(~gen_next(), 1'b1, 1'b0);
        end
        settle();
        chk("t2_pulses",  ep_seen - ep0, 5);
        chk("t2_err_cnt", err_cnt, 5);
        chk("t2_locked",  locked, 1);
        for (int k = 0; k < 400; k++) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                b = gen_next();
                if ($urandom_range(0, 63) == 0) b = ~b;
                send(b, 1'b1, 1'b0);
            end else begin
                send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end

        // 3: burst of 32 errors at the start of a fresh window
        send(1'b0, 1'b0, 1'b1); settle();
        chk("t3_clr_bit_cnt", bit_cnt, 0);
        do send_clean(1); while (win_n != 0);
        sl0 = sl_seen;
        for (int k = 0; k < 32; k++) send(~gen_next(), 1'b1, 1'b0);
        settle();
        chk("t3_sync_loss", sl_seen - sl0, 1);
        chk("t3_unlocked",  locked, 0);
        chk("t3_err_cnt",   err_cnt, 32);
        lock_check("t3_relock");
        chk("t3_err_hold",  err_cnt, 32);

        // 6: async reset while locked
        send_clean(50);
        hard_reset();
        lock_check("t6_relock");

        // 4: all-zero seed rejection, then a VERIFY-stage error
        hard_reset();
        for (int k = 0; k < 22; k++) send(1'b0, 1'b1, 1'b0);
        send_clean(22);
        send_clean(10);
        send(~gen_next(), 1'b1, 1'b0);
        settle();
        chk("t4_unlocked", locked, 0);
        lock_check("t4_lock");

        // 5: alternating valid, then clr coinciding with an error
        hard_reset();
        for (int k = 0; k < 86; k++) begin
            send(gen_next(), 1'b1, 1'b0);
            if (k == 84) begin settle(); chk("t5_unlocked_at_85", locked, 0); end
            if (k == 85) begin settle(); chk("t5_locked_at_86",   locked, 1); end
            send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        send_clean(20);
        send(~gen_next(), 1'b1, 1'b1); settle();
        chk("t5_clr_err_pulse", err_pulse, 1);
        chk("t5_clr_err_cnt",   err_cnt, 0);
        chk("t5_clr_bit_cnt",   bit_cnt, 0);
        send(1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge sclk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
